// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard,
        StFault
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Fixed-priority next-PC mux: trap > redirect > sequential. Also exports the
// aligned control-flow target alone so other blocks can reuse it.
module next_pc_sel
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_trap_valid,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_take,
    output logic [XLEN-1:0] o_target,
    output logic [XLEN-1:0] o_pc_next
);

    logic w_unused_low_bits;

    // Low bits are forced to zero, so they never reach the fetch address.
    assign w_unused_low_bits = ^i_redirect_pc[1:0];

    always_comb begin
        o_take   = i_trap_valid | i_redirect_valid;
        o_target = i_trap_valid ? TRAP_VEC : {i_redirect_pc[XLEN-1:2], 2'b00};
        o_pc_next = o_take ? o_target : i_pc + 32'd4;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents one instruction at a time to decode and flags imem timeouts.
module fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic            fetch_fault
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_addr;
    logic             r_req;
    logic [XLEN-1:0]  r_instr;
    logic             r_instr_valid;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;

    logic             w_take;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_resume_pc;

    next_pc_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc_sel (
        .i_pc             (r_pc),
        .i_trap_valid     (trap_valid),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_take           (w_take),
        .o_target         (w_target),
        .o_pc_next        (w_pc_next)
    );

    // Address to fetch when DISCARD ends; a same-cycle redirect/trap still wins.
    assign w_resume_pc = w_take ? w_target : r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_req         <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_state <= StFetch;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_cnt   <= '0;
                end
                StFetch: begin
                    if (w_take) begin
                        r_pc  <= w_target;
                        r_cnt <= '0;
                        if (imem_ack) begin
                            r_addr <= w_target;
                        end else begin
                            r_state <= StDiscard;
                        end
                    end else if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_req         <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= StHold;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= StFault;
                        r_req         <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_fault       <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHold: begin
                    // Redirect/trap overrides stall and drops the held instruction.
                    if (!stall || w_take) begin
                        r_pc          <= w_pc_next;
                        r_addr        <= w_pc_next;
                        r_req         <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= StFetch;
                    end
                end
                StDiscard: begin
                    if (w_take) begin
                        r_pc <= w_target;
                    end
                    if (imem_ack) begin
                        r_addr  <= w_resume_pc;
                        r_cnt   <= '0;
                        r_state <= StFetch;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= StFault;
                        r_req         <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_fault       <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StFault: begin
                    if (trap_valid) begin
                        r_pc    <= TRAP_VEC;
                        r_addr  <= TRAP_VEC;
                        r_req   <= 1'b1;
                        r_fault <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StFetch;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign pc          = r_pc;
    assign pc_next     = w_pc_next;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_fault = r_fault;

endmodule
